mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed data memory interface; sits in the MEM stage between the pipeline and the byte-wide data memory.
- Accepts one load/store request at a time (byte, halfword or word; signed or unsigned loads).
- Sequences the access into one memory byte per cycle, big-endian: lowest address holds the MSB.
- Assembles and extends load data, splits store data into bytes, reports misaligned and out-of-range accesses as faults, and stalls the pipeline while busy.

Parameters:
- MEM_BYTES, 36, number of bytes in the data memory; valid addresses are 0..MEM_BYTES-1.
- ADDR_W, 6, width of mem_addr; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted on a clock edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid.
- stall  out  1  pipeline hold.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  memory write byte.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  8  memory read byte; valid the cycle after mem_rd.

Behaviour:
- Reset:
  - Any clock edge with reset low forces state IDLE.
  - resp_valid = 0, resp_fault = 0, resp_rdata = 0, mem_rd = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, byte counter = 0.
  - req_ready = 1 from the first edge with reset low.
- Reset mid-operation: the access is abandoned and no resp_valid is produced. Bytes already written stay written. The unit is idle on the next cycle.
- Accept: all req_* fields are captured into registers at the accept edge (cycle 0). Inputs may change afterwards.
- Byte count n = 1, 2 or 4 for size 0, 1 or 2.
- Fault check, done at accept:
  - size == 3;
  - half with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr + n > MEM_BYTES, evaluated on the full 32-bit address with no wrap.
  - On fault: state goes to RESP; resp_valid = 1 and resp_fault = 1 in cycle 1; resp_rdata = 0. No mem_rd or mem_wr is ever asserted.
- States:
  - IDLE: req_ready = 1, stall = 0.
  - ACCESS: issues byte k in cycle k+1, for k = 0..n-1.
  - DRAIN: loads only; captures the last byte.
  - RESP: one cycle with resp_valid = 1, then back to IDLE.
- Store timing:
  - Cycle k+1: mem_wr = 1, mem_addr = addr+k, mem_wdata = wdata[8(n-k)-1 -: 8].
  - Example: a half store writes wdata[15:8] to addr and wdata[7:0] to addr+1.
  - resp_valid is asserted in cycle n+1. Word store completes in cycle 5, byte store in cycle 2.
- Load timing:
  - Cycle k+1: mem_rd = 1, mem_addr = addr+k.
  - mem_rdata is shifted into an assembly register at the end of cycle k+2.
  - resp_valid is asserted in cycle n+2. Word load completes in cycle 6, byte load in cycle 3.
- Load result:
  - Byte: {24 x ext, b0}.
  - Half: {16 x ext, b0, b1}.
  - Word: {b0, b1, b2, b3}.
  - ext = req_signed ? MSB of the loaded value : 0.
- Handshake and stall:
  - stall = (state != IDLE). It is low again the cycle after RESP.
  - req_ready = (state == IDLE). A request presented during RESP is not accepted until the next cycle.
  - The response has no backpressure.
- Strobes: mem_rd and mem_wr are never high together, and are low outside ACCESS.
- Registers: resp_rdata holds its value until the next resp_valid. mem_addr and mem_wdata may hold their values when the strobes are low.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;
  - state encodings IDLE, ACCESS, DRAIN, RESP;
  - function returning byte count from size.
- One natural sub-module: mem_load_extend. Combinational assembly of the byte register plus sign/zero extension by size. Everything else stays in mem_access_unit.

Test Plan:
- Memory model preloaded with bytes 0..7 = 96 96 96 96 02 00 00 00.
- Word load at addr 0 -> mem_rd in cycles 1-4 with mem_addr 0,1,2,3; resp_valid in cycle 6; resp_rdata = 0x96969696; resp_fault = 0; stall high in cycles 1-6.
- Byte load at addr 0, signed -> 0xFFFFFF96 in cycle 3. Same access unsigned -> 0x00000096. Half load at addr 4, signed -> 0x00000200.
- Word store at addr 8, data 0xDEADBEEF -> mem_wr writes 8:DE, 9:AD, 10:BE, 11:EF; resp_valid in cycle 5. A following word load at addr 8 -> 0xDEADBEEF.
- Half store at addr 6, data 0x1234ABCD -> writes 6:AB, 7:CD. A following word load at addr 4 -> 0x0200ABCD.
- Fault cases -> resp_fault = 1 in cycle 1, zero mem_rd/mem_wr pulses, req_ready = 1 in cycle 2:
  - word at addr 2;
  - half at addr 5;
  - word at addr 36;
  - size = 3.
- Word store at addr 12 with reset driven low in cycle 2 -> only byte 12 written; no resp_valid; req_ready = 1 and stall = 0 after the reset edge. A following word load at addr 0 completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package mem_access_pkg;

  // Access size encodings as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Number of memory bytes touched by an access of the given size.
  // The reserved size maps to 1 so downstream arithmetic stays in range;
  // such requests are faulted and never reach the memory.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Turns the right-justified, big-endian assembled load bytes into the
// final load result, applying sign or zero extension by access size.
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic w_ext_byte;
  logic w_ext_half;

  assign w_ext_byte = i_signed & i_bytes[7];
  assign w_ext_half = i_signed & i_bytes[15];

  // Select the live bytes for the size and fill the upper bits with the extension bit
  always_comb begin
    o_data = i_bytes;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_ext_byte}}, i_bytes[7:0]};
      SZ_HALF: o_data = {{16{w_ext_half}}, i_bytes[15:0]};
      default: o_data = i_bytes;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the byte-wide data memory: sequences one load/store
// request into single-byte accesses (big-endian), assembles load data,
// faults misaligned/out-of-range requests and stalls the pipeline while busy.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 36,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata
);

  state_t r_state;
  state_t w_state_next;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cnt;
  logic              r_fault;
  logic              r_rd_pending;
  logic [23:0]       r_asm;
  logic [31:0]       r_resp_rdata;

  logic        w_accept;
  logic [2:0]  w_req_n;
  logic        w_req_fault;
  logic [2:0]  w_n;
  logic        w_last;
  logic [1:0]  w_byte_sel;
  logic [31:0] w_asm_full;
  logic [31:0] w_load_value;

  // Request decode: the full 32-bit address is range-checked without wrap
  assign w_accept = req_valid && (r_state == IDLE);
  assign w_req_n  = byte_count(req_size);
  assign w_req_fault = (req_size == 2'd3)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || (({1'b0, req_addr} + 33'(w_req_n)) > 33'(MEM_BYTES));

  // Byte sequencing of the captured request
  assign w_n        = byte_count(r_size);
  assign w_last     = (r_cnt == (w_n - 3'd1));
  assign w_byte_sel = 2'(w_n - 3'd1 - r_cnt);
  assign mem_addr   = r_addr + ADDR_W'(r_cnt);

  // Byte arriving this cycle appended to the bytes already collected
  assign w_asm_full = {r_asm, mem_rdata};

  mem_load_extend u_extend (
    .i_bytes  (w_asm_full),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_value)
  );

  assign resp_rdata = r_resp_rdata;

  // Store byte for the current step: most significant live byte goes first
  always_comb begin
    mem_wdata = r_wdata[7:0];
    case (w_byte_sel)
      2'd0:    mem_wdata = r_wdata[7:0];
      2'd1:    mem_wdata = r_wdata[15:8];
      2'd2:    mem_wdata = r_wdata[23:16];
      default: mem_wdata = r_wdata[31:24];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/strobe outputs; strobes drop while reset is
  // held so an abandoned access writes nothing further
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    stall        = 1'b1;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    resp_valid   = 1'b0;
    resp_fault   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (w_accept) begin
          w_state_next = w_req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_rd = !r_write && reset;
        mem_wr = r_write && reset;
        if (w_last) begin
          w_state_next = r_write ? RESP : DRAIN;
        end
      end
      DRAIN: begin
        w_state_next = RESP;
      end
      default: begin
        resp_valid   = 1'b1;
        resp_fault   = r_fault;
        w_state_next = IDLE;
      end
    endcase
  end

  // Request capture, byte counter, load assembly and response data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_fault      <= 1'b0;
      r_rd_pending <= 1'b0;
      r_asm        <= '0;
      r_resp_rdata <= '0;
    end else begin
      r_rd_pending <= mem_rd;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr[ADDR_W-1:0];
        r_wdata  <= req_wdata;
        r_cnt    <= '0;
        r_fault  <= w_req_fault;
        if (w_req_fault) begin
          r_resp_rdata <= '0;
        end
      end
      if (r_rd_pending) begin
        r_asm <= w_asm_full[23:0];
      end else if (w_accept) begin
        r_asm <= '0;
      end
      if (r_state == ACCESS) begin
        if (!w_last) begin
          r_cnt <= r_cnt + 3'd1;
        end else if (r_write) begin
          r_resp_rdata <= '0;
        end
      end
      if (r_state == DRAIN) begin
        r_resp_rdata <= w_load_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-wide memory model plus a
// byte-array reference of memory contents and the access rules.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 36;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_rdata;

  logic [7:0] tb_mem  [0:63];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  // Byte-wide data memory with registered read
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, act, exp);
    end
  endtask

  // One request, traced cycle by cycle and compared with the rule-based reference
  task automatic do_access(input bit wr, input logic [1:0] sz, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit exp_fault;
    longint unsigned a64;
    longint unsigned acc;
    logic [31:0] exp_rdata;
    int exp_resp;
    int resp_cyc;
    logic [31:0] got_rdata;
    logic got_fault;
    logic ready_at_resp;
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];
    int stall_bad;
    int both_bad;

    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a64 = addr;
    exp_fault = (sz == 2'd3) || ((a64 % longint'(n)) != 0) || ((a64 + longint'(n)) > MEM_BYTES);
    acc = 0;
    if (!exp_fault && !wr) begin
      for (int k = 0; k < n; k++) acc = (acc << 8) | 64'(ref_mem[int'(addr) + k]);
      if (sgn && acc[8*n-1]) acc = acc | (~64'd0 << (8*n));
    end
    exp_rdata = (exp_fault || wr) ? 32'd0 : acc[31:0];
    exp_resp  = exp_fault ? 1 : (wr ? n + 1 : n + 2);

    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    resp_cyc = 0; stall_bad = 0; both_bad = 0;
    got_rdata = '0; got_fault = 1'b0; ready_at_resp = 1'b1;
    for (int c = 1; c <= 12 && resp_cyc == 0; c++) begin
      @(negedge clk);
      if (!stall) stall_bad++;
      if (mem_rd && mem_wr) both_bad++;
      if (mem_rd) rd_q.push_back({8'(c), 8'(mem_addr), 8'h00});
      if (mem_wr) wr_q.push_back({8'(c), 8'(mem_addr), mem_wdata});
      if (resp_valid) begin
        resp_cyc = c; got_rdata = resp_rdata; got_fault = resp_fault; ready_at_resp = req_ready;
      end
    end

    check("resp_cycle", resp_cyc, exp_resp);
    check("resp_fault", got_fault, exp_fault);
    check("resp_rdata", got_rdata, exp_rdata);
    check("ready_in_resp", ready_at_resp, 0);
    check("stall_low_busy", stall_bad, 0);
    check("rd_wr_overlap", both_bad, 0);
    check("rd_count", rd_q.size(), (!exp_fault && !wr) ? n : 0);
    check("wr_count", wr_q.size(), (!exp_fault && wr) ? n : 0);
    if (!exp_fault) begin
      for (int k = 0; k < n; k++) begin
        if (!wr && k < rd_q.size())
          check($sformatf("rd%0d_cyc_addr", k), rd_q[k], {8'(k + 1), 8'(int'(addr) + k), 8'h00});
        if (wr && k < wr_q.size())
          check($sformatf("wr%0d_cyc_addr_data", k), wr_q[k],
                {8'(k + 1), 8'(int'(addr) + k), 8'(wd >> (8 * (n - 1 - k)))});
      end
      if (wr) for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = 8'(wd >> (8 * (n - 1 - k)));
    end

    @(negedge clk);
    check("ready_after", req_ready, 1);
    check("stall_after", stall, 0);
    check("rdata_hold", resp_rdata, exp_rdata);

    n_txn++;
    $display("txn %0d wr=%0d size=%0d signed=%0d addr=%08h wdata=%08h resp@%0d fault=%0d rdata=%08h",
             n_txn, wr, sz, sgn, addr, wd, resp_cyc, got_fault, got_rdata);
  endtask

  initial begin
    logic [7:0] preload [8];
    int rv_seen;
    int diffs;
    bit wr;
    bit sgn;
    logic [1:0] sz;
    logic [31:0] addr;
    int sel;

    preload = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h02, 8'h00, 8'h00, 8'h00};
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) tb_mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) tb_mem[i] = preload[i];
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = tb_mem[i];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b1;

    // Directed accesses from the preloaded image
    do_access(0, 2'd2, 0, 32'd0, 32'd0);
    do_access(0, 2'd0, 1, 32'd0, 32'd0);
    do_access(0, 2'd0, 0, 32'd0, 32'd0);
    do_access(0, 2'd1, 1, 32'd4, 32'd0);
    do_access(1, 2'd2, 0, 32'd8, 32'hDEADBEEF);
    do_access(0, 2'd2, 0, 32'd8, 32'd0);
    do_access(1, 2'd1, 0, 32'd6, 32'h1234ABCD);
    do_access(0, 2'd2, 0, 32'd4, 32'd0);
    // Faults and range boundaries
    do_access(0, 2'd2, 0, 32'd2, 32'd0);
    do_access(0, 2'd1, 0, 32'd5, 32'd0);
    do_access(0, 2'd2, 0, 32'd36, 32'd0);
    do_access(1, 2'd3, 0, 32'd0, 32'h55555555);
    do_access(0, 2'd2, 0, 32'hFFFFFFFC, 32'd0);
    do_access(1, 2'd0, 0, 32'd36, 32'h000000AA);
    do_access(1, 2'd0, 0, 32'd35, 32'h00000081);
    do_access(0, 2'd1, 1, 32'd34, 32'd0);
    do_access(0, 2'd2, 1, 32'd32, 32'd0);

    // Reset in the middle of a word store: only the first byte lands
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'd12; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_c1_wr", mem_wr, 1);
    check("rstmid_c1_addr", 32'(mem_addr), 12);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rv_seen = 0;
    @(negedge clk);
    if (resp_valid) rv_seen++;
    check("rstmid_wr_gated", mem_wr, 0);
    @(posedge clk);
    #1;
    check("rstmid_ready", req_ready, 1);
    check("rstmid_stall", stall, 0);
    reset = 1'b1;
    ref_mem[12] = 8'hCA;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check("rstmid_no_resp", rv_seen, 0);
    $display("txn reset-abandoned word store addr=0000000c");
    do_access(0, 2'd2, 0, 32'd0, 32'd0);
    do_access(0, 2'd2, 0, 32'd12, 32'd0);

    // Randomized accesses, biased towards aligned addresses near the top of memory
    for (int t = 0; t < 150; t++) begin
      wr  = 1'($urandom);
      sgn = 1'($urandom);
      sel = $urandom_range(0, 9);
      sz  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 15) == 0) begin
        sel  = $urandom_range(0, 3);
        addr = (sel == 0) ? 32'hFFFFFFFC : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'h00000100 : 32'd40;
      end else begin
        addr = $urandom_range(0, 39);
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) addr[0] = 1'b0;
          if (sz == 2'd2) addr[1:0] = 2'b00;
        end
      end
      do_access(wr, sz, sgn, addr, $urandom);
    end

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    check("memory_image", diffs, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
